// File: rtl/chacha_arb.sv
// chacha_arb: two-requester round-robin front end for a single ChaCha core.
// Accepts one job at a time, latches its operands, pulses the core, waits for
// the result (bounded by TIMEOUT cycles) and returns it to the granted requester.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready      job handshake for requester N (ready is combinational)
//   reqN_key/ctr/iv/data         job operands for requester N
//   rspN_valid                   one-cycle response strobe for requester N
//   rsp_data / rsp_err           shared response block / timeout flag (held)
//   core_next                    one-cycle start pulse to the core
//   core_key/ctr/iv/data         latched operands to the core
//   core_ready / core_valid      core idle / core result strobe
//   core_dout                    core result block
//   busy                         FSM is not idle
module chacha_arb #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [255:0] req0_key,
  input  logic [63:0]  req0_ctr,
  input  logic [63:0]  req0_iv,
  input  logic [511:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [255:0] req1_key,
  input  logic [63:0]  req1_ctr,
  input  logic [63:0]  req1_iv,
  input  logic [511:0] req1_data,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [511:0] rsp_data,
  output logic         rsp_err,
  output logic         core_next,
  output logic [255:0] core_key,
  output logic [63:0]  core_ctr,
  output logic [63:0]  core_iv,
  output logic [511:0] core_data,
  input  logic         core_ready,
  input  logic         core_valid,
  input  logic [511:0] core_dout,
  output logic         busy
);

  localparam int unsigned KEY_W = 256;
  localparam int unsigned CTR_W = 64;
  localparam int unsigned IV_W  = 64;
  localparam int unsigned BLK_W = 512;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [CTR_W-1:0] ctr;
    logic [IV_W-1:0]  iv;
    logic [BLK_W-1:0] data;
  } job_t;

  state_t           state_q;
  state_t           state_d;
  logic             rr_q;
  logic             id_q;
  job_t             job_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BLK_W-1:0] rsp_data_q;
  logic             rsp_err_q;

  logic             accept_c;
  logic             timeout_c;
  job_t             job0_c;
  job_t             job1_c;

  assign job0_c    = '{key: req0_key, ctr: req0_ctr, iv: req0_iv, data: req0_data};
  assign job1_c    = '{key: req1_key, ctr: req1_ctr, iv: req1_iv, data: req1_data};
  assign accept_c  = req0_ready | req1_ready;
  // Last WAIT cycle: counter starts at 0 on WAIT entry, so TIMEOUT WAIT cycles in total.
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_c) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (core_valid || timeout_c) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode; grant favours rr_q, falls back to the other valid requester.
  // reset_n gates the grant so no ready can leak out while reset is asserted.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    core_next  = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (core_ready && reset_n) begin
          if (!rr_q) begin
            req0_ready = req0_valid;
            req1_ready = req1_valid & ~req0_valid;
          end else begin
            req1_ready = req1_valid;
            req0_ready = req0_valid & ~req1_valid;
          end
        end
      end
      ST_ISSUE: core_next = 1'b1;
      ST_RESP: begin
        rsp0_valid = ~id_q;
        rsp1_valid = id_q;
      end
      default: ;
    endcase
  end

  // Holding registers, timeout counter, response capture and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q       <= 1'b0;
      id_q       <= 1'b0;
      job_q      <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept_c) begin
        job_q <= req1_ready ? job1_c : job0_c;
        id_q  <= req1_ready;
      end
      if (state_q == ST_ISSUE)     cnt_q <= '0;
      else if (state_q == ST_WAIT) cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == ST_WAIT) begin
        if (core_valid) begin
          rsp_data_q <= core_dout;
          rsp_err_q  <= 1'b0;
        end else if (timeout_c) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
      end
      if (state_q == ST_RESP) rr_q <= ~id_q;
    end
  end

  assign core_key  = job_q.key;
  assign core_ctr  = job_q.ctr;
  assign core_iv   = job_q.iv;
  assign core_data = job_q.data;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_chacha_arb.sv
// Bench for chacha_arb: directed scenarios plus a randomized phase, checked
// cycle-by-cycle against a transaction-level reference model.
module tb_chacha_arb;

  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [255:0] req0_key = '0, req1_key = '0;
  logic [63:0]  req0_ctr = '0, req1_ctr = '0, req0_iv = '0, req1_iv = '0;
  logic [511:0] req0_data = '0, req1_data = '0;
  logic         rsp0_valid, rsp1_valid, rsp_err, core_next, busy;
  logic [511:0] rsp_data, core_data;
  logic [255:0] core_key;
  logic [63:0]  core_ctr, core_iv;
  logic         core_ready = 1'b1;
  logic         core_valid = 1'b0;
  logic [511:0] core_dout = '0;

  chacha_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key),
    .req0_ctr(req0_ctr), .req0_iv(req0_iv), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key),
    .req1_ctr(req1_ctr), .req1_iv(req1_iv), .req1_data(req1_data),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .core_next(core_next), .core_key(core_key),
    .core_ctr(core_ctr), .core_iv(core_iv), .core_data(core_data),
    .core_ready(core_ready), .core_valid(core_valid), .core_dout(core_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] mix(input logic [255:0] k, input logic [63:0] c,
                                       input logic [63:0] v, input logic [511:0] d);
    return d ^ {k, k} ^ {8{c ^ {v[31:0], v[63:32]}}};
  endfunction

  function automatic logic [511:0] r512();
    logic [511:0] x;
    for (int i = 0; i < 16; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  // Core model: answers core_lat cycles after core_next (0 = never); stray strobes on demand.
  int unsigned  core_lat = 0;
  bit           core_fixed = 1'b0;
  int unsigned  pend = 0;
  int unsigned  stray_req = 0, stray_done = 0;
  logic [511:0] c_out = '0;

  always @(negedge clk) begin
    core_valid = 1'b0;
    if (!reset_n) begin
      pend = 0;
    end else begin
      if (pend != 0) begin
        pend--;
        if (pend == 0) begin
          core_valid = 1'b1;
          core_dout  = c_out;
        end
      end
      if (stray_req != stray_done) begin
        stray_done = stray_req;
        core_valid = 1'b1;
        core_dout  = '1;
      end
      if (core_next) begin
        pend  = core_lat;
        c_out = core_fixed ? {64{8'hA5}} : mix(core_key, core_ctr, core_iv, core_data);
      end
    end
  end

  // Reference model state (transaction level: one job in flight, timed by arithmetic)
  int           n_pass = 0, n_fail = 0, n_total = 0;
  int           k = 0;
  bit           m_act = 1'b0, m_err = 1'b0, m_herr = 1'b0;
  int           m_id = 0, m_next = 0, m_rsp = 0, m_rr = 0;
  logic [255:0] m_k = '0;
  logic [63:0]  m_c = '0, m_v = '0;
  logic [511:0] m_d = '0, m_data = '0, m_hold = '0;
  int unsigned  next_lat = 5;
  bit           rearm0 = 1'b0, rearm1 = 1'b0, rnd = 1'b0, acc0, acc1;
  int           obs_g[$], obs_r[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, update the model, advance to next negedge.
  task automatic cycle();
    int g;
    #1;
    g = -1;
    if (!m_act && core_ready) begin
      if (m_rr == 0) g = req0_valid ? 0 : (req1_valid ? 1 : -1);
      else           g = req1_valid ? 1 : (req0_valid ? 0 : -1);
    end
    if (m_act && k == m_rsp) begin
      m_hold = m_data;
      m_herr = m_err;
    end
    chk("req0_ready", 512'(req0_ready), 512'(g == 0));
    chk("req1_ready", 512'(req1_ready), 512'(g == 1));
    chk("busy", 512'(busy), 512'(m_act));
    chk("core_next", 512'(core_next), 512'(m_act && k == m_next));
    chk("rsp0_valid", 512'(rsp0_valid), 512'(m_act && k == m_rsp && m_id == 0));
    chk("rsp1_valid", 512'(rsp1_valid), 512'(m_act && k == m_rsp && m_id == 1));
    chk("rsp_data", rsp_data, m_hold);
    chk("rsp_err", 512'(rsp_err), 512'(m_herr));
    if (m_act) begin
      chk("core_key", 512'(core_key), 512'(m_k));
      chk("core_ctr", 512'(core_ctr), 512'(m_c));
      chk("core_iv", 512'(core_iv), 512'(m_v));
      chk("core_data", core_data, m_d);
    end
    acc0 = req0_ready && req0_valid;
    acc1 = req1_ready && req1_valid;
    if (acc0) obs_g.push_back(0);
    if (acc1) obs_g.push_back(1);
    if (rsp0_valid) obs_r.push_back(0);
    if (rsp1_valid) obs_r.push_back(1);
    if (m_act && k == m_rsp) begin
      m_act = 1'b0;
      m_rr  = 1 - m_id;
    end
    if (g >= 0) begin
      m_act  = 1'b1;
      m_id   = g;
      m_k    = (g == 0) ? req0_key : req1_key;
      m_c    = (g == 0) ? req0_ctr : req1_ctr;
      m_v    = (g == 0) ? req0_iv : req1_iv;
      m_d    = (g == 0) ? req0_data : req1_data;
      m_next = k + 1;
      m_err  = (next_lat == 0);
      m_rsp  = m_err ? k + 2 + int'(TO) : k + 2 + int'(next_lat);
      m_data = m_err ? '0 : (core_fixed ? {64{8'hA5}} : mix(m_k, m_c, m_v, m_d));
      core_lat = next_lat;
    end
    @(negedge clk);
    k++;
  endtask

  task automatic step();
    cycle();
    if (acc0) begin
      req0_key = r512()[255:0]; req0_ctr = {$urandom, $urandom};
      req0_iv = {$urandom, $urandom}; req0_data = r512(); req0_valid = rearm0;
    end
    if (acc1) begin
      req1_key = r512()[255:0]; req1_ctr = {$urandom, $urandom};
      req1_iv = {$urandom, $urandom}; req1_data = r512(); req1_valid = rearm1;
    end
    if (rnd) begin
      core_ready = ($urandom_range(0, 4) != 0);
      next_lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1'b1; req0_data = r512(); req0_key = r512()[255:0];
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1'b1; req1_data = r512(); req1_ctr = {$urandom, $urandom};
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset, check every output immediately, hold for n cycles; caller releases.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    #1;
    chk("rst_req0_ready", 512'(req0_ready), 512'(0));
    chk("rst_req1_ready", 512'(req1_ready), 512'(0));
    chk("rst_rsp0_valid", 512'(rsp0_valid), 512'(0));
    chk("rst_rsp1_valid", 512'(rsp1_valid), 512'(0));
    chk("rst_core_next", 512'(core_next), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_rsp_data", rsp_data, 512'(0));
    chk("rst_rsp_err", 512'(rsp_err), 512'(0));
    chk("rst_core_data", core_data, 512'(0));
    chk("rst_core_key", 512'(core_key), 512'(0));
    m_act = 1'b0; m_rr = 0; m_hold = '0; m_herr = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int exp_o[4];
    exp_o = '{0, 1, 0, 1};
    @(negedge clk);
    do_reset(2);
    reset_n = 1'b1;

    // Single job with fixed core pattern, latency 5
    core_fixed = 1'b1; next_lat = 5;
    req0_key = '0; req0_ctr = 64'd1; req0_iv = '0; req0_data = '0; req0_valid = 1'b1;
    run(12);
    chk("single_grants", 512'(obs_g.size()), 512'(1));
    chk("single_rsps", 512'(obs_r.size()), 512'(1));

    // Contention: both valid from reset, expect 0,1,0,1
    do_reset(2);
    obs_g.delete(); obs_r.delete();
    core_fixed = 1'b0; next_lat = 3; rearm0 = 1'b1; rearm1 = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = r512(); req1_data = r512();
    reset_n = 1'b1;
    for (int i = 0; i < 80 && obs_r.size() < 4; i++) step();
    req0_valid = 1'b0; req1_valid = 1'b0; rearm0 = 1'b0; rearm1 = 1'b0;
    chk("contention_grants", 512'(obs_g.size()), 512'(4));
    chk("contention_rsps", 512'(obs_r.size()), 512'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < obs_g.size()) chk("contention_order", 512'(obs_g[i]), 512'(exp_o[i]));
      if (i < obs_r.size()) chk("contention_rsp_id", 512'(obs_r[i]), 512'(exp_o[i]));
    end
    run(2);

    // core_ready low blocks acceptance; grant appears in the cycle it rises
    obs_g.delete(); obs_r.delete();
    core_ready = 1'b0; req1_valid = 1'b1; req1_data = r512();
    run(10);
    chk("core_ready_low_grants", 512'(obs_g.size()), 512'(0));
    core_ready = 1'b1;
    run(1);
    chk("core_ready_rise_grants", 512'(obs_g.size()), 512'(1));
    if (obs_g.size() == 1) chk("core_ready_rise_id", 512'(obs_g[0]), 512'(1));
    run(8);

    // Timeout, then a stray core_valid while idle
    obs_g.delete(); obs_r.delete();
    next_lat = 0; req0_valid = 1'b1; req0_data = r512();
    run(14);
    chk("timeout_rsps", 512'(obs_r.size()), 512'(1));
    stray_req++;
    run(4);
    chk("stray_no_rsp", 512'(obs_r.size()), 512'(1));

    // Reset during WAIT of a requester-1 job
    obs_g.delete(); obs_r.delete();
    next_lat = 0; req1_valid = 1'b1; req1_data = r512();
    run(4);
    req0_valid = 1'b1;
    do_reset(2);
    next_lat = 2; req1_valid = 1'b1;
    reset_n = 1'b1;
    run(1);
    chk("post_reset_grant0", 512'(obs_g.size()), 512'(2));
    if (obs_g.size() == 2) chk("post_reset_grant_id", 512'(obs_g[1]), 512'(0));
    run(14);
    chk("post_reset_rsps", 512'(obs_r.size()), 512'(2));
    if (obs_r.size() == 2) begin
      chk("post_reset_rsp_a", 512'(obs_r[0]), 512'(0));
      chk("post_reset_rsp_b", 512'(obs_r[1]), 512'(1));
    end

    // Randomized traffic
    obs_g.delete(); obs_r.delete();
    rnd = 1'b1;
    run(400);
    rnd = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; core_ready = 1'b1; next_lat = 3;
    run(14);
    chk("random_balance", 512'(obs_r.size()), 512'(obs_g.size()));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
